gpsreceiver2_capture: RTL

GPSRECEIVER2_CAPTURE -- requirements
Module: gpsreceiver2_capture

---
 rtl/gpsreceiver2_pkg.sv | 25 ++
 rtl/gpsreceiver2_packer.sv | 38 +++
 rtl/gpsreceiver2_capture.sv | 128 ++++++++++++
 3 files changed

// File: rtl/gpsreceiver2_pkg.sv
// Shared types and sizing for the GPS sample capture block.
// Buffer is 2048 bytes of four 2-bit {sign,mag} samples each.
package gpsreceiver2_pkg;

    localparam int BUF_BYTES        = 2048;
    localparam int ADR_W            = 11;
    localparam int SAMPLES_PER_BYTE = 4;
    localparam int LEN_W            = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    // Zero or anything above the buffer size means a full buffer.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        if (len == '0 || len > LEN_W'(BUF_BYTES)) begin
            return LEN_W'(BUF_BYTES);
        end
        return len;
    endfunction

endpackage

// File: rtl/gpsreceiver2_packer.sv
// Packs 2-bit samples into bytes, sample k at bits [2k+1:2k].
// byte_valid is combinational with the 4th strobe; clear drops any partial byte.
module gpsreceiver2_packer
    import gpsreceiver2_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [1:0] sample_dat,
    input  logic       sample_stb,
    output logic [7:0] byte_dat,
    output logic       byte_valid
);

    localparam logic [1:0] LAST_IDX = 2'(SAMPLES_PER_BYTE - 1);

    logic [5:0] partial;
    logic [1:0] idx;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            partial <= '0;
            idx     <= '0;
        end else if (sample_stb) begin
            case (idx)
                2'd0:    partial[1:0] <= sample_dat;
                2'd1:    partial[3:2] <= sample_dat;
                2'd2:    partial[5:4] <= sample_dat;
                default: partial      <= '0;
            endcase
            idx <= idx + 2'd1;
        end
    end

    assign byte_dat   = {sample_dat, partial};
    assign byte_valid = sample_stb && !clear && (idx == LAST_IDX);

endmodule

// File: rtl/gpsreceiver2_capture.sv
// Captures packed GPS front-end samples into a 2048-byte buffer, one registered write per byte.
// Define GPSRECEIVER2_PPS_TRIGGER_EN to hold ARMED until a pps rising edge; otherwise ARMED lasts one cycle.
module gpsreceiver2_capture
    import gpsreceiver2_pkg::*;
(
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             sample_sign,
    input  logic             sample_mag,
    input  logic             sample_stb,
    input  logic             pps,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] cap_len,
    output logic [7:0]       rxb0_dat,
    output logic [ADR_W-1:0] rxb0_adr,
    output logic             rxb0_we,
    output logic             busy,
    output logic             done,
    output logic             irq,
    output logic [LEN_W-1:0] byte_count
);

    cap_state_t       state;
    cap_state_t       state_nxt;
    logic             capturing;
    logic             accept_start;
    logic             byte_valid;
    logic [7:0]       byte_dat;
    logic             write_ok;
    logic             last_byte;
    logic             pps_go;
    logic [LEN_W-1:0] len_q;

    assign capturing    = (state == ST_CAPTURE) && !abort;
    assign accept_start = start && !abort && (state == ST_IDLE || state == ST_DONE);
    assign write_ok     = capturing && byte_valid;
    assign last_byte    = (byte_count + LEN_W'(1)) == len_q;
    assign busy         = (state == ST_ARMED) || (state == ST_CAPTURE);

`ifdef GPSRECEIVER2_PPS_TRIGGER_EN
    logic pps_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pps_q <= 1'b0;
        end else begin
            pps_q <= pps;
        end
    end

    assign pps_go = pps && !pps_q;
`else
    logic unused_pps;
    assign unused_pps = pps;
    assign pps_go     = 1'b1;
`endif

    // Packer only runs in CAPTURE, so ARMED-phase samples and aborted partials vanish.
    gpsreceiver2_packer u_packer (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .clear      (!capturing),
        .sample_dat ({sample_sign, sample_mag}),
        .sample_stb (sample_stb),
        .byte_dat   (byte_dat),
        .byte_valid (byte_valid)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept_start) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (abort)       state_nxt = ST_IDLE;
                else if (pps_go) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (abort)                      state_nxt = ST_IDLE;
                else if (write_ok && last_byte) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write port registers hold between strobes; the final write lands with DONE and irq.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rxb0_we    <= 1'b0;
            rxb0_dat   <= '0;
            rxb0_adr   <= '0;
            done       <= 1'b0;
            irq        <= 1'b0;
            byte_count <= '0;
            len_q      <= LEN_W'(BUF_BYTES);
        end else begin
            rxb0_we <= 1'b0;
            irq     <= 1'b0;
            if (accept_start) begin
                done       <= 1'b0;
                byte_count <= '0;
                rxb0_adr   <= '0;
                len_q      <= eff_len(cap_len);
            end
            if (write_ok) begin
                rxb0_we    <= 1'b1;
                rxb0_dat   <= byte_dat;
                rxb0_adr   <= byte_count[ADR_W-1:0];
                byte_count <= byte_count + LEN_W'(1);
                if (last_byte) begin
                    done <= 1'b1;
                    irq  <= 1'b1;
                end
            end
        end
    end

endmodule
